// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//   Rhythm-game song sequencer. Waits on the main screen for a start key,
//   spawns one circle per beat (type taken from the pattern table), paces the
//   beats with a tick-driven gap counter, tracks how many spawned circles are
//   still live, then judges the song against the player's health.
//
// Ports
//   Clk            in   system clock, all state changes on the rising edge
//   Reset          in   asynchronous active-low reset
//   keycode        in   current keyboard keycode (held while key is down)
//   tick           in   one-cycle frame tick pacing the gap counter
//   health         in   current player health (unsigned)
//   out_of_bounds  in   one-cycle pulse: one live circle was resolved
//   pattern        in   beat type table, beat i at [i*TYPE_W +: TYPE_W]
//   main           out  main screen select
//   playbackground out  play screen select (song running or paused)
//   fail           out  fail screen select
//   success        out  success screen select
//   paused         out  pause overlay select
//   spawn          out  one-cycle circle spawn pulse
//   circletype     out  type of the circle being spawned, 0 when not spawning
//   beat_idx       out  index of the current or next beat
//   live_cnt       out  number of spawned, unresolved circles
// -----------------------------------------------------------------------------
module beat_sequencer #(
  parameter int unsigned NUM_BEATS   = 8,
  parameter int unsigned TYPE_W      = 2,
  parameter int unsigned GAP_TICKS   = 30,
  parameter int unsigned HEALTH_W    = 4,
  parameter int unsigned PASS_HEALTH = 2,
  parameter logic [7:0]  KEY_START   = 8'd44,
  parameter logic [7:0]  KEY_QUIT    = 8'd20,
  parameter logic [7:0]  KEY_PAUSE   = 8'd19
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          tick,
  input  logic [HEALTH_W-1:0]           health,
  input  logic                          out_of_bounds,
  input  logic [NUM_BEATS*TYPE_W-1:0]   pattern,
  output logic                          main,
  output logic                          playbackground,
  output logic                          fail,
  output logic                          success,
  output logic                          paused,
  output logic                          spawn,
  output logic [TYPE_W-1:0]             circletype,
  output logic [$clog2(NUM_BEATS)-1:0]  beat_idx,
  output logic [$clog2(NUM_BEATS):0]    live_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_BEATS);
  localparam int unsigned LIVE_W = IDX_W + 1;
  localparam int unsigned GAP_W  = 16;

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_BEATS - 1);
  localparam logic [GAP_W-1:0]    GAP_LOAD    = GAP_W'(GAP_TICKS);
  localparam logic [HEALTH_W-1:0] PASS_THRESH = HEALTH_W'(PASS_HEALTH);

  typedef enum logic [3:0] {
    ST_MAIN  = 4'd0,
    ST_START = 4'd1,
    ST_SPAWN = 4'd2,
    ST_GAP   = 4'd3,
    ST_DRAIN = 4'd4,
    ST_JUDGE = 4'd5,
    ST_PAUSE = 4'd6,
    ST_FAILS = 4'd7,
    ST_PASSS = 4'd8
  } state_e;

  state_e            state_q, state_d;
  state_e            save_q,  save_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic [LIVE_W-1:0] live_q,  live_d;
  logic [7:0]        key_q;

  logic press_start;
  logic press_quit;
  logic press_pause;
  logic abort;
  logic spawn_now;

  // Key press = first cycle the code appears; a held key acts once.
  assign press_start = (keycode == KEY_START) && (key_q != KEY_START);
  assign press_quit  = (keycode == KEY_QUIT)  && (key_q != KEY_QUIT);
  assign press_pause = (keycode == KEY_PAUSE) && (key_q != KEY_PAUSE);

  assign abort     = press_quit || (health == '0);
  assign spawn_now = (state_q == ST_SPAWN);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_MAIN;
      save_q  <= ST_GAP;
      idx_q   <= '0;
      gap_q   <= '0;
      live_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      save_q  <= save_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      live_q  <= live_d;
      key_q   <= keycode;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    save_d  = save_q;
    idx_d   = idx_q;
    gap_d   = gap_q;

    unique case (state_q)
      ST_MAIN: begin
        if (press_start) state_d = ST_START;
      end

      ST_START: begin
        idx_d = '0;
        gap_d = '0;
        if (abort) state_d = ST_FAILS;
        else       state_d = ST_SPAWN;
      end

      ST_SPAWN: begin
        if (abort) begin
          state_d = ST_FAILS;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end

      // Zero test comes before the tick decrement so that a zero gap still
      // costs exactly one GAP cycle between spawns.
      ST_GAP: begin
        if (abort) begin
          state_d = ST_FAILS;
        end else if (press_pause) begin
          save_d  = ST_GAP;
          state_d = ST_PAUSE;
        end else if (gap_q == '0) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SPAWN;
        end else if (tick) begin
          gap_d = gap_q - 1'b1;
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_FAILS;
        end else if (press_pause) begin
          save_d  = ST_DRAIN;
          state_d = ST_PAUSE;
        end else if (live_q == '0) begin
          state_d = ST_JUDGE;
        end
      end

      ST_JUDGE: begin
        if (health >= PASS_THRESH) state_d = ST_PASSS;
        else                       state_d = ST_FAILS;
      end

      ST_PAUSE: begin
        if (abort)            state_d = ST_FAILS;
        else if (press_pause) state_d = save_q;
      end

      ST_FAILS, ST_PASSS: begin
        if (press_start) state_d = ST_MAIN;
      end

      default: state_d = ST_MAIN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Live circle counter: simultaneous spawn and resolve cancel out; it never
  // wraps below zero or above full scale.
  // ---------------------------------------------------------------------------
  always_comb begin
    live_d = live_q;
    if (state_q == ST_START) begin
      live_d = '0;
    end else if (spawn_now && !out_of_bounds) begin
      if (live_q != '1) live_d = live_q + 1'b1;
    end else if (!spawn_now && out_of_bounds) begin
      if (live_q != '0) live_d = live_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode; an illegal encoding shows the main screen for the one
  // cycle before it recovers.
  // ---------------------------------------------------------------------------
  always_comb begin
    main           = 1'b0;
    playbackground = 1'b0;
    fail           = 1'b0;
    success        = 1'b0;
    paused         = 1'b0;
    unique case (state_q)
      ST_MAIN:                                    main           = 1'b1;
      ST_START, ST_SPAWN, ST_GAP, ST_DRAIN,
      ST_JUDGE:                                   playbackground = 1'b1;
      ST_PAUSE: begin
        playbackground = 1'b1;
        paused         = 1'b1;
      end
      ST_FAILS:                                   fail           = 1'b1;
      ST_PASSS:                                   success        = 1'b1;
      default:                                    main           = 1'b1;
    endcase
  end

  always_comb begin
    circletype = '0;
    if (spawn_now) begin
      for (int unsigned i = 0; i < NUM_BEATS; i++) begin
        if (idx_q == IDX_W'(i)) circletype = pattern[i*TYPE_W +: TYPE_W];
      end
    end
  end

  assign spawn    = spawn_now;
  assign beat_idx = idx_q;
  assign live_cnt = live_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
//   Directed bench for beat_sequencer with default parameters, plus a second
//   instance with GAP_TICKS=0 watched for back-to-back spawn spacing.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic        tick;
  logic [3:0]  health;
  logic        out_of_bounds;
  logic [15:0] pattern;

  logic       main, playbackground, fail, success, paused, spawn;
  logic [1:0] circletype;
  logic [2:0] beat_idx;
  logic [3:0] live_cnt;

  logic       f_main, f_play, f_fail, f_success, f_paused, f_spawn;
  logic [1:0] f_type;
  logic [2:0] f_idx;
  logic [3:0] f_live;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int onehot_bad = 0;
  logic fmon_en = 1'b0;
  int fcnt   = 0;
  int ffirst = 0;
  int flast  = 0;

  beat_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .tick(tick), .health(health),
    .out_of_bounds(out_of_bounds), .pattern(pattern),
    .main(main), .playbackground(playbackground), .fail(fail), .success(success),
    .paused(paused), .spawn(spawn), .circletype(circletype),
    .beat_idx(beat_idx), .live_cnt(live_cnt)
  );

  beat_sequencer #(.GAP_TICKS(0)) u_fast (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .tick(tick), .health(health),
    .out_of_bounds(out_of_bounds), .pattern(pattern),
    .main(f_main), .playbackground(f_play), .fail(f_fail), .success(f_success),
    .paused(f_paused), .spawn(f_spawn), .circletype(f_type),
    .beat_idx(f_idx), .live_cnt(f_live)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if ((32'(main) + 32'(playbackground) + 32'(fail) + 32'(success)) != 1) onehot_bad++;
    if (fmon_en && f_spawn) begin
      fcnt++;
      if (fcnt == 1) ffirst = cyc;
      flast = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_spawn(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(negedge Clk);
      n++;
      if (spawn) break;
    end
  endtask

  // Starts a song from MAIN/ending screen-to-MAIN and checks all 8 spawns.
  task automatic play_song(input string tag);
    int n;
    keycode = 8'd44;
    for (int k = 0; k < 8; k++) begin
      wait_spawn(40, n);
      if (k == 0) keycode = 8'd0;
      chk({tag, "_spawn"}, 32'(spawn), 32'd1);
      chk({tag, "_gap"}, 32'(n), (k == 0) ? 32'd2 : 32'd32);
      chk({tag, "_type"}, 32'(circletype), 32'(k % 4));
      chk({tag, "_idx"}, 32'(beat_idx), 32'(k));
    end
  endtask

  initial begin
    int n;
    int bad;
    Reset = 1'b0; keycode = 8'd0; tick = 1'b1; health = 4'd3;
    out_of_bounds = 1'b0; pattern = 16'hE4E4;

    // Reset state
    #12;
    chk("rst_main", 32'(main), 32'd1);
    chk("rst_outs", {26'd0, playbackground, fail, success, paused, spawn, 1'b0}, 32'd0);
    chk("rst_type", 32'(circletype), 32'd0);
    chk("rst_idx", 32'(beat_idx), 32'd0);
    chk("rst_live", 32'(live_cnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    step(1);
    chk("post_rst_spawn", 32'(spawn), 32'd0);
    chk("post_rst_main", 32'(main), 32'd1);

    // Stray resolve at zero
    out_of_bounds = 1'b1; step(1); out_of_bounds = 1'b0;
    chk("stray_oob_live", 32'(live_cnt), 32'd0);

    // Song 1: pass
    fmon_en = 1'b1;
    play_song("s1");
    fmon_en = 1'b0;
    chk("fast_count", 32'(fcnt), 32'd8);
    chk("fast_span", 32'(flast - ffirst), 32'd14);
    step(1);
    chk("s1_drain_live", 32'(live_cnt), 32'd8);
    chk("s1_drain_play", 32'(playbackground), 32'd1);
    chk("s1_drain_type", 32'(circletype), 32'd0);
    repeat (7) begin
      out_of_bounds = 1'b1; step(1); out_of_bounds = 1'b0; step(1);
    end
    chk("s1_live1", 32'(live_cnt), 32'd1);
    out_of_bounds = 1'b1; step(1); out_of_bounds = 1'b0;
    chk("s1_live0", 32'(live_cnt), 32'd0);
    chk("s1_still_drain", 32'(success), 32'd0);
    step(1);
    chk("s1_judge_play", 32'(playbackground), 32'd1);
    step(1);
    chk("s1_success", 32'(success), 32'd1);
    chk("s1_success_play", 32'(playbackground), 32'd0);

    // Song 2: fail on low health
    keycode = 8'd44; step(1);
    chk("s2_to_main", 32'(main), 32'd1);
    keycode = 8'd0; step(1);
    play_song("s2");
    health = 4'd1;
    out_of_bounds = 1'b1; step(8); out_of_bounds = 1'b0;
    chk("s2_live0", 32'(live_cnt), 32'd0);
    step(2);
    chk("s2_fail", 32'(fail), 32'd1);
    chk("s2_not_main", 32'(main), 32'd0);
    keycode = 8'd44; step(1);
    chk("s2_back_main", 32'(main), 32'd1);
    keycode = 8'd0; health = 4'd3; step(1);

    // Song 3: simultaneous spawn/resolve, pause, quit
    keycode = 8'd44;
    wait_spawn(40, n);
    chk("s3_first", 32'(n), 32'd2);
    keycode = 8'd0;
    wait_spawn(40, n);
    wait_spawn(40, n);
    chk("s3_b2_idx", 32'(beat_idx), 32'd2);
    chk("s3_live_pre", 32'(live_cnt), 32'd2);
    out_of_bounds = 1'b1; step(1); out_of_bounds = 1'b0;
    chk("s3_live_same", 32'(live_cnt), 32'd2);
    step(20);
    keycode = 8'd19; step(1);
    chk("s3_paused", 32'(paused), 32'd1);
    chk("s3_pause_idx", 32'(beat_idx), 32'd2);
    bad = 0;
    repeat (100) begin
      step(1);
      if (!paused || spawn) bad++;
    end
    chk("s3_pause_hold", 32'(bad), 32'd0);
    keycode = 8'd0; step(1);
    chk("s3_still_paused", 32'(paused), 32'd1);
    keycode = 8'd19; step(1);
    chk("s3_resumed", 32'(paused), 32'd0);
    chk("s3_resumed_play", 32'(playbackground), 32'd1);
    keycode = 8'd0;
    wait_spawn(40, n);
    chk("s3_resume_gap", 32'(n), 32'd11);
    chk("s3_b3_idx", 32'(beat_idx), 32'd3);
    chk("s3_b3_type", 32'(circletype), 32'd3);
    keycode = 8'd20; step(1);
    chk("s3_quit_fail", 32'(fail), 32'd1);
    bad = 0;
    repeat (50) begin
      step(1);
      if (spawn || !fail) bad++;
    end
    chk("s3_quit_hold", 32'(bad), 32'd0);
    keycode = 8'd0; step(1);
    keycode = 8'd44; step(1);
    chk("s3_to_main", 32'(main), 32'd1);
    step(3);
    chk("s3_held_start", 32'(main), 32'd1);
    keycode = 8'd0; step(1);

    // Song 4: zero health aborts
    keycode = 8'd44;
    wait_spawn(40, n);
    chk("s4_first", 32'(n), 32'd2);
    keycode = 8'd0; health = 4'd0; step(1);
    chk("s4_health0_fail", 32'(fail), 32'd1);
    health = 4'd3; keycode = 8'd44; step(1);
    chk("s4_to_main", 32'(main), 32'd1);
    keycode = 8'd0; step(1);

    // Song 5: asynchronous reset mid-gap
    keycode = 8'd44;
    wait_spawn(40, n);
    keycode = 8'd0;
    step(5);
    chk("s5_in_gap", 32'(playbackground), 32'd1);
    chk("s5_live", 32'(live_cnt), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("s5_arst_main", 32'(main), 32'd1);
    chk("s5_arst_play", 32'(playbackground), 32'd0);
    chk("s5_arst_spawn", 32'(spawn), 32'd0);
    chk("s5_arst_live", 32'(live_cnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    step(1);
    chk("s5_rel_spawn", 32'(spawn), 32'd0);
    chk("s5_rel_main", 32'(main), 32'd1);

    chk("onehot", 32'(onehot_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
